// File: rtl/io_interface.sv
// rtl/io_interface.sv - memory-mapped UART transmitter and receiver
// Control at 0x80000000, receive data at 0x80000004, transmit data at 0x80000008.
module io_interface #(
   parameter int ClockFreq = 100_000_000,
   parameter int BaudRate  = 115_200
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [31:0] rd2,
   input  logic [31:0] Addr,
   input  logic [3:0]  IO_trans,
   input  logic        IO_recv,
   input  logic        FPGA_Sin,
   output logic        FPGA_Sout,
   output logic [31:0] Received
);

   localparam int SymbolEdgeTime = ClockFreq / BaudRate;
   localparam int CntW = $clog2(SymbolEdgeTime);
   localparam logic [CntW-1:0] SymLast  = CntW'(SymbolEdgeTime - 1);
   localparam logic [CntW-1:0] HalfLast = CntW'(SymbolEdgeTime / 2 - 1);

   localparam logic [31:0] ADDR_CTRL = 32'h8000_0000;
   localparam logic [31:0] ADDR_RXD  = 32'h8000_0004;
   localparam logic [31:0] ADDR_TXD  = 32'h8000_0008;

   localparam logic [0:0] TX_IDLE  = 1'b0;
   localparam logic [0:0] TX_SHIFT = 1'b1;

   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

   logic [0:0]      tx_state = TX_IDLE;
   logic [9:0]      tx_shift = 10'h3FF;
   logic [3:0]      tx_bits  = 4'd0;
   logic [CntW-1:0] tx_cnt   = '0;
   logic            tx_ready;
   logic            tx_accept;

   logic [1:0]      rx_state = RX_IDLE;
   logic [CntW-1:0] rx_cnt   = '0;
   logic [2:0]      rx_bits  = 3'd0;
   logic [7:0]      rx_shift = 8'h00;
   logic [7:0]      rx_data  = 8'h00;
   logic            rx_valid = 1'b0;
   logic            rx_done;
   logic            rx_pop;

   logic            sin_meta = 1'b1;
   logic            sin_sync = 1'b1;
   logic            sin_prev = 1'b1;

   logic            unused_ok;
   assign unused_ok = ^{rd2[31:8], IO_trans[3:1]};

   assign tx_ready  = (tx_state == TX_IDLE);
   assign tx_accept = tx_ready && (Addr == ADDR_TXD) && IO_trans[0];
   assign FPGA_Sout = (tx_state == TX_SHIFT) ? tx_shift[0] : 1'b1;

   // Frame is {stop, data[7:0], start}, shifted out LSB first.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         tx_state <= TX_IDLE;
         tx_shift <= 10'h3FF;
         tx_bits  <= 4'd0;
         tx_cnt   <= '0;
      end else begin
         case (tx_state)
            TX_IDLE: begin
               if (tx_accept) begin
                  tx_shift <= {1'b1, rd2[7:0], 1'b0};
                  tx_bits  <= 4'd0;
                  tx_cnt   <= '0;
                  tx_state <= TX_SHIFT;
               end
            end
            default: begin
               if (tx_cnt == SymLast) begin
                  tx_cnt   <= '0;
                  tx_shift <= {1'b1, tx_shift[9:1]};
                  if (tx_bits == 4'd9) tx_state <= TX_IDLE;
                  else                 tx_bits  <= tx_bits + 4'd1;
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         sin_meta <= 1'b1;
         sin_sync <= 1'b1;
         sin_prev <= 1'b1;
      end else begin
         sin_meta <= FPGA_Sin;
         sin_sync <= sin_meta;
         sin_prev <= sin_sync;
      end
   end

   assign rx_done = (rx_state == RX_STOP) && (rx_cnt == SymLast);
   assign rx_pop  = (Addr == ADDR_RXD) && IO_recv;

   // After the half-symbol start check, every later sample lands mid-bit.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bits  <= 3'd0;
         rx_shift <= 8'h00;
      end else begin
         case (rx_state)
            RX_IDLE: begin
               rx_cnt <= '0;
               if (sin_prev && !sin_sync) rx_state <= RX_START;
            end
            RX_START: begin
               if (rx_cnt == HalfLast) begin
                  rx_cnt   <= '0;
                  rx_bits  <= 3'd0;
                  rx_state <= sin_sync ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (rx_cnt == SymLast) begin
                  rx_cnt   <= '0;
                  rx_shift <= {sin_sync, rx_shift[7:1]};
                  if (rx_bits == 3'd7) rx_state <= RX_STOP;
                  else                 rx_bits  <= rx_bits + 3'd1;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            default: begin
               if (rx_cnt == SymLast) begin
                  rx_cnt   <= '0;
                  rx_state <= RX_IDLE;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
         endcase
      end
   end

   // A completing byte takes priority over a pop on the same edge.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         rx_data  <= 8'h00;
         rx_valid <= 1'b0;
      end else if (rx_done) begin
         rx_data  <= rx_shift;
         rx_valid <= 1'b1;
      end else if (rx_pop) begin
         rx_valid <= 1'b0;
      end
   end

   always_comb begin
      Received = 32'h0;
      case (Addr)
         ADDR_CTRL: Received = {30'b0, rx_valid, tx_ready};
         ADDR_RXD:  Received = {24'b0, rx_data};
         default:   Received = 32'h0;
      endcase
   end

endmodule

// File: tb/tb_io_interface.sv
// tb/tb_io_interface.sv - directed bench for the memory-mapped UART
module tb_io_interface;

   localparam int BIT  = 868;
   localparam int HALF = 434;
   localparam logic [31:0] CTRL = 32'h8000_0000;
   localparam logic [31:0] RXD  = 32'h8000_0004;
   localparam logic [31:0] TXD  = 32'h8000_0008;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic [31:0] rd2 = 32'h0;
   logic [31:0] Addr = 32'h0;
   logic [3:0]  IO_trans = 4'h0;
   logic        IO_recv = 1'b0;
   logic        FPGA_Sin;
   logic        FPGA_Sout;
   logic [31:0] Received;

   logic        loop = 1'b0;
   logic        sin_drv = 1'b1;
   int          tests = 0;
   int          errors = 0;

   assign FPGA_Sin = loop ? FPGA_Sout : sin_drv;

   always #5 Clock = ~Clock;

   io_interface dut (
      .Clock(Clock), .Reset(Reset), .rd2(rd2), .Addr(Addr),
      .IO_trans(IO_trans), .IO_recv(IO_recv), .FPGA_Sin(FPGA_Sin),
      .FPGA_Sout(FPGA_Sout), .Received(Received)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      Addr = a;
      #1;
      d = Received;
   endtask

   task automatic tx_write(input logic [7:0] b);
      @(negedge Clock);
      Addr = TXD;
      rd2 = {24'hA5C3E1, b};
      IO_trans = 4'b0001;
      @(negedge Clock);
      IO_trans = 4'b0000;
      Addr = CTRL;
   endtask

   task automatic uart_send(input logic [7:0] b);
      logic [9:0] frame;
      frame = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         sin_drv = frame[i];
         repeat (BIT) @(negedge Clock);
      end
   endtask

   task automatic uart_recv(output logic [7:0] b, output logic st, output logic sp, output logic fd);
      int n;
      n = 0;
      b = 8'h00; st = 1'b1; sp = 1'b0;
      while (FPGA_Sout !== 1'b0 && n < 20000) begin
         @(negedge Clock);
         n++;
      end
      fd = (FPGA_Sout === 1'b0);
      if (fd) begin
         repeat (HALF) @(negedge Clock);
         st = FPGA_Sout;
         for (int i = 0; i < 8; i++) begin
            repeat (BIT) @(negedge Clock);
            b[i] = FPGA_Sout;
         end
         repeat (BIT) @(negedge Clock);
         sp = FPGA_Sout;
      end
   endtask

   task automatic wait_ctrl_bit(input int bitn, output int n, output logic [31:0] d);
      n = 0;
      rd(CTRL, d);
      while (!d[bitn] && n < 20000) begin
         @(negedge Clock);
         n++;
         rd(CTRL, d);
      end
   endtask

   task automatic count_low(input int cycles, output int lows);
      lows = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge Clock);
         if (FPGA_Sout !== 1'b1) lows++;
      end
   endtask

   initial begin
      logic [31:0] d;
      logic [7:0]  b;
      logic        st, sp, fd;
      int          n;

      repeat (3) @(negedge Clock);
      Reset = 1'b0;
      @(negedge Clock);

      check("rst_sout", {31'b0, FPGA_Sout}, 32'h1);
      rd(CTRL, d);        check("rst_ctrl", d, 32'h0000_0001);
      rd(RXD, d);         check("rst_rxd", d, 32'h0000_0000);
      rd(32'h1234_5678, d); check("rst_other", d, 32'h0);

      // External byte into the receiver, then pop it.
      uart_send(8'hAA);
      wait_ctrl_bit(1, n, d);
      check("rx_aa_ctrl", d, 32'h3);
      IO_recv = 1'b1;
      rd(RXD, d);         check("rx_aa_data", d, 32'h0000_00AA);
      @(negedge Clock);
      IO_recv = 1'b0;
      rd(CTRL, d);        check("rx_aa_popped", d, 32'h1);
      rd(RXD, d);         check("rx_aa_hold", d, 32'h0000_00AA);

      // Transmit 0xFF and capture it with an external receiver.
      tx_write(8'hFF);
      rd(CTRL, d);        check("tx_ff_busy", d, 32'h0);
      uart_recv(b, st, sp, fd);
      check("tx_ff_found", {31'b0, fd}, 32'h1);
      check("tx_ff_start", {31'b0, st}, 32'h0);
      check("tx_ff_data", {24'b0, b}, 32'h0000_00FF);
      check("tx_ff_stop", {31'b0, sp}, 32'h1);
      wait_ctrl_bit(0, n, d);
      check("tx_ff_ready_delay", n, HALF);

      // Loopback of 0x5A.
      loop = 1'b1;
      tx_write(8'h5A);
      wait_ctrl_bit(1, n, d);
      check("lb_valid", {31'b0, d[1]}, 32'h1);
      IO_recv = 1'b1;
      rd(RXD, d);         check("lb_data", d, 32'h0000_005A);
      @(negedge Clock);
      IO_recv = 1'b0;
      wait_ctrl_bit(0, n, d);
      check("lb_ready", d, 32'h1);
      loop = 1'b0;
      repeat (10) @(negedge Clock);

      // Write while busy is dropped.
      tx_write(8'h22);
      fork
         uart_recv(b, st, sp, fd);
         begin
            repeat (200) @(negedge Clock);
            Addr = TXD;
            rd2 = 32'h0000_0011;
            IO_trans = 4'b0001;
            @(negedge Clock);
            IO_trans = 4'b0000;
            Addr = CTRL;
         end
      join
      check("busy_data", {24'b0, b}, 32'h0000_0022);
      check("busy_stop", {31'b0, sp}, 32'h1);
      wait_ctrl_bit(0, n, d);
      count_low(2000, n);
      check("busy_no_second", n, 0);

      // Reset in the middle of a transmit frame.
      tx_write(8'h33);
      repeat (3000) @(negedge Clock);
      Reset = 1'b1;
      @(negedge Clock);
      Reset = 1'b0;
      check("midrst_sout", {31'b0, FPGA_Sout}, 32'h1);
      rd(CTRL, d);        check("midrst_ctrl", d, 32'h1);
      count_low(1000, n);
      check("midrst_quiet", n, 0);

      // Short low pulses are not start bits.
      sin_drv = 1'b0;
      @(negedge Clock);
      sin_drv = 1'b1;
      repeat (2000) @(negedge Clock);
      rd(CTRL, d);        check("glitch_1cyc", d, 32'h1);
      sin_drv = 1'b0;
      repeat (300) @(negedge Clock);
      sin_drv = 1'b1;
      repeat (2000) @(negedge Clock);
      rd(CTRL, d);        check("glitch_300cyc", d, 32'h1);

      // Overrun: second byte overwrites the first, valid stays set.
      uart_send(8'h3C);
      uart_send(8'hC3);
      wait_ctrl_bit(1, n, d);
      check("ovr_ctrl", d, 32'h3);
      rd(RXD, d);         check("ovr_data", d, 32'h0000_00C3);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
